rtc_alarm_clock: RTL and testbench

Parametrised real-time clock with a 12/24-hour display format, pushbutton time setting with field selection, and a daily alarm. It is the timekeeping core between the board clock and the seven-segment display driver: it divides `clk_50MHz` down to a 1 Hz tick, maintains hh:mm:ss, and exposes display-ready counters, a 1 Hz square wave and an alarm output. The clock frequency is a parameter so benches run with small dividers.

---
 rtl/rtc_alarm_clock.sv | 182 ++++++++++++++++++
 tb/tb_rtc_alarm_clock.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_alarm_clock.sv
// rtl/rtc_alarm_clock.sv - hh:mm:ss real-time clock with 12/24-hour display, pushbutton setting and daily alarm
// Divides the board clock to a 1 Hz tick; display outputs are muxed only from registers.
module rtc_alarm_clock #(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int ALARM_SECONDS = 60
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic [1:0] pushKey,
  input  logic       fmt_12h,
  input  logic       alarm_en,
  output logic       clk_1Hz,
  output logic [5:0] hour_counter,
  output logic [5:0] min_counter,
  output logic [5:0] sec_counter,
  output logic       pm,
  output logic [1:0] field_sel,
  output logic       alarm_ring
);

  localparam int            PW       = $clog2(CLK_FREQ_HZ);
  localparam logic [PW-1:0] P_LAST   = PW'(CLK_FREQ_HZ - 1);
  localparam logic [PW-1:0] P_HALF   = PW'(CLK_FREQ_HZ / 2 - 1);
  localparam logic [7:0]    RING_LEN = 8'(ALARM_SECONDS);

  typedef enum logic [1:0] {
    MODE_RUN       = 2'b00,
    MODE_SET_TIME  = 2'b01,
    MODE_SET_ALARM = 2'b10,
    MODE_RUN_ALT   = 2'b11
  } mode_e;

  logic [4:0]    hh_q, hh_d, ah_q, ah_d;
  logic [5:0]    mm_q, mm_d, ss_q, ss_d, am_q, am_d;
  logic [PW-1:0] p_q, p_d;
  logic [1:0]    key_q;
  logic [1:0]    field_q, field_d;
  logic [7:0]    ring_cnt_q, ring_cnt_d;
  logic          ring_q, ring_d;
  logic          clk1_q, clk1_d;
  mode_e         mode_q;
  logic          fmt_q;

  mode_e      cur_mode;
  logic       set_time, set_alarm, tick, alarm_hit;
  logic [1:0] press;

  assign cur_mode  = mode_e'(mode);
  assign set_time  = (cur_mode == MODE_SET_TIME);
  assign set_alarm = (cur_mode == MODE_SET_ALARM);
  assign press     = key_q & ~pushKey;
  assign tick      = !set_time && (p_q == P_LAST);

  always_comb begin
    hh_d       = hh_q;
    mm_d       = mm_q;
    ss_d       = ss_q;
    ah_d       = ah_q;
    am_d       = am_q;
    p_d        = p_q;
    field_d    = field_q;
    ring_d     = ring_q;
    ring_cnt_d = ring_cnt_q;
    clk1_d     = clk1_q;
    alarm_hit  = 1'b0;

    if (set_time || tick) p_d = '0;
    else                  p_d = p_q + 1'b1;

    if (set_time)              clk1_d = 1'b0;
    else if (tick)             clk1_d = 1'b1;
    else if (p_q == P_HALF)    clk1_d = 1'b0;

    if (tick) begin
      if (ss_q == 6'd59) begin
        ss_d = '0;
        if (mm_q == 6'd59) begin
          mm_d = '0;
          hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
        end else begin
          mm_d = mm_q + 6'd1;
        end
      end else begin
        ss_d = ss_q + 6'd1;
      end
    end

    // Field edits never carry into neighbouring fields.
    if (set_time && press[0]) begin
      case (field_q)
        2'd0:    hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
        2'd1:    mm_d = (mm_q == 6'd59) ? 6'd0 : mm_q + 6'd1;
        default: ss_d = '0;
      endcase
    end
    if (set_alarm && press[0]) begin
      case (field_q)
        2'd0:    ah_d = (ah_q == 5'd23) ? 5'd0 : ah_q + 5'd1;
        2'd1:    am_d = (am_q == 6'd59) ? 6'd0 : am_q + 6'd1;
        default: ;
      endcase
    end
    if ((set_time || set_alarm) && press[1])
      field_d = (field_q == 2'd2) ? 2'd0 : field_q + 2'd1;

    alarm_hit = tick && alarm_en && (hh_d == ah_q) && (mm_d == am_q) && (ss_d == 6'd0);

    if ((press != 2'b00) || !alarm_en || set_time) begin
      ring_d     = 1'b0;
      ring_cnt_d = '0;
    end else if (alarm_hit) begin
      ring_d     = 1'b1;
      ring_cnt_d = RING_LEN;
    end else if (ring_q && tick) begin
      ring_cnt_d = ring_cnt_q - 8'd1;
      if (ring_cnt_q == 8'd1) ring_d = 1'b0;
    end
  end

  // Display selects are sampled so outputs never follow mode/fmt inputs combinationally.
  always_ff @(posedge clk_50MHz) begin
    mode_q <= cur_mode;
    fmt_q  <= fmt_12h;
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      hh_q       <= '0;
      mm_q       <= '0;
      ss_q       <= '0;
      ah_q       <= '0;
      am_q       <= '0;
      p_q        <= '0;
      key_q      <= 2'b11;
      field_q    <= '0;
      ring_cnt_q <= '0;
      ring_q     <= 1'b0;
      clk1_q     <= 1'b0;
    end else begin
      hh_q       <= hh_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      ah_q       <= ah_d;
      am_q       <= am_d;
      p_q        <= p_d;
      key_q      <= pushKey;
      field_q    <= field_d;
      ring_cnt_q <= ring_cnt_d;
      ring_q     <= ring_d;
      clk1_q     <= clk1_d;
    end
  end

  logic [4:0] disp_h;

  always_comb begin
    disp_h      = hh_q;
    min_counter = mm_q;
    sec_counter = ss_q;
    if (mode_q == MODE_SET_ALARM) begin
      disp_h      = ah_q;
      min_counter = am_q;
      sec_counter = '0;
    end
    hour_counter = {1'b0, disp_h};
    pm           = 1'b0;
    if (fmt_q) begin
      if (disp_h == 5'd0) begin
        hour_counter = 6'd12;
      end else if (disp_h >= 5'd12) begin
        pm = 1'b1;
        if (disp_h > 5'd12) hour_counter = {1'b0, disp_h - 5'd12};
      end
    end
  end

  assign clk_1Hz    = clk1_q;
  assign field_sel  = field_q;
  assign alarm_ring = ring_q;

endmodule

// File: tb/tb_rtc_alarm_clock.sv
// tb/tb_rtc_alarm_clock.sv - self-checking bench for rtc_alarm_clock
// Time-of-day model in seconds since midnight, checked every cycle, plus literal pins.
module tb_rtc_alarm_clock;

  localparam int N    = 8;
  localparam int RING = 3;

  logic       clk;
  logic       reset;
  logic [1:0] mode;
  logic [1:0] pushKey;
  logic       fmt_12h;
  logic       alarm_en;
  logic       clk_1Hz;
  logic [5:0] hour_counter, min_counter, sec_counter;
  logic       pm;
  logic [1:0] field_sel;
  logic       alarm_ring;

  rtc_alarm_clock #(.CLK_FREQ_HZ(N), .ALARM_SECONDS(RING)) dut (
    .clk_50MHz    (clk),
    .reset        (reset),
    .mode         (mode),
    .pushKey      (pushKey),
    .fmt_12h      (fmt_12h),
    .alarm_en     (alarm_en),
    .clk_1Hz      (clk_1Hz),
    .hour_counter (hour_counter),
    .min_counter  (min_counter),
    .sec_counter  (sec_counter),
    .pm           (pm),
    .field_sel    (field_sel),
    .alarm_ring   (alarm_ring)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Model state: time and alarm as plain counts since midnight.
  int         t_sec, a_min, phase, ring_left, fsel;
  bit         m_clk, m_ring, m_show_alarm, m_fmt;
  logic [1:0] prev_key;

  task automatic model_step();
    logic [1:0] fall;
    bit ticked, in_set, in_aset;
    int h, m, s;
    in_set       = (mode == 2'b01);
    in_aset      = (mode == 2'b10);
    m_show_alarm = in_aset;
    m_fmt        = fmt_12h;
    if (reset) begin
      t_sec = 0; a_min = 0; phase = 0; ring_left = 0; fsel = 0;
      m_clk = 0; m_ring = 0; prev_key = 2'b11;
      return;
    end
    fall     = prev_key & ~pushKey;
    prev_key = pushKey;
    ticked   = 0;
    if (in_set) begin
      phase = 0;
      m_clk = 0;
    end else begin
      phase++;
      if (phase == N) begin
        phase = 0; ticked = 1; m_clk = 1;
        t_sec = (t_sec + 1) % 86400;
      end else if (phase == N / 2) begin
        m_clk = 0;
      end
    end
    h = t_sec / 3600; m = (t_sec / 60) % 60; s = t_sec % 60;
    if (fall[0] && in_set) begin
      if (fsel == 0)      t_sec = ((h + 1) % 24) * 3600 + m * 60 + s;
      else if (fsel == 1) t_sec = h * 3600 + ((m + 1) % 60) * 60 + s;
      else                t_sec = h * 3600 + m * 60;
    end
    if (fall[0] && in_aset) begin
      if (fsel == 0)      a_min = ((a_min / 60 + 1) % 24) * 60 + a_min % 60;
      else if (fsel == 1) a_min = (a_min / 60) * 60 + (a_min % 60 + 1) % 60;
    end
    if (fall[1] && (in_set || in_aset)) fsel = (fsel + 1) % 3;
    if (fall != 2'b00 || !alarm_en || in_set) begin
      m_ring = 0; ring_left = 0;
    end else if (ticked && t_sec == a_min * 60) begin
      m_ring = 1; ring_left = RING;
    end else if (ticked && m_ring) begin
      ring_left--;
      if (ring_left == 0) m_ring = 0;
    end
  endtask

  always @(posedge clk) model_step();

  task automatic check_cycle();
    int eh, em, es, ehc, epm;
    if (m_show_alarm) begin
      eh = a_min / 60; em = a_min % 60; es = 0;
    end else begin
      eh = t_sec / 3600; em = (t_sec / 60) % 60; es = t_sec % 60;
    end
    ehc = eh; epm = 0;
    if (m_fmt) begin
      epm = (eh >= 12) ? 1 : 0;
      ehc = (eh % 12 == 0) ? 12 : eh % 12;
    end
    chk("hour_counter", int'(hour_counter), ehc);
    chk("min_counter",  int'(min_counter),  em);
    chk("sec_counter",  int'(sec_counter),  es);
    chk("pm",           int'(pm),           epm);
    chk("field_sel",    int'(field_sel),    fsel);
    chk("clk_1Hz",      int'(clk_1Hz),      int'(m_clk));
    chk("alarm_ring",   int'(alarm_ring),   int'(m_ring));
  endtask

  always @(negedge clk) if (chk_en) check_cycle();

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input int b, input int n);
    repeat (n) begin
      pushKey[b] = 1'b0;
      step(1);
      pushKey[b] = 1'b1;
      step(1);
    end
  endtask

  task automatic wait_ring(input string name);
    int i = 0;
    while (!alarm_ring && i < 600) begin
      step(1);
      i++;
    end
    chk(name, int'(alarm_ring), 1);
  endtask

  task automatic set_alarm_min_plus_one();
    mode = 2'b10;
    press(1, 1);
    press(0, 1);
    press(1, 2);
    mode = 2'b00;
  endtask

  initial begin
    reset = 1'b1; mode = 2'b00; pushKey = 2'b11; fmt_12h = 1'b1; alarm_en = 1'b0;
    step(2);
    reset  = 1'b0;
    chk_en = 1'b1;
    chk("reset_hour_12h", int'(hour_counter), 12);
    chk("reset_pm", int'(pm), 0);
    chk("reset_clk", int'(clk_1Hz), 0);
    chk("reset_ring", int'(alarm_ring), 0);
    fmt_12h = 1'b0;
    step(7);
    chk("first_rise_before", int'(clk_1Hz), 0);
    step(1);
    chk("first_rise", int'(clk_1Hz), 1);
    chk("first_sec", int'(sec_counter), 1);

    // Set time: hour wrap, single-shot hold, frozen seconds.
    mode = 2'b01;
    press(0, 25);
    chk("hour_wrap_25", int'(hour_counter), 1);
    press(0, 22);
    press(1, 1);
    chk("field_step", int'(field_sel), 1);
    pushKey = 2'b10;
    step(100);
    chk("hold_once", int'(min_counter), 1);
    pushKey = 2'b11;
    step(1);
    chk("sec_frozen", int'(sec_counter), 1);
    press(0, 58);
    press(1, 1);
    press(0, 1);
    press(1, 1);
    mode = 2'b00;

    // Rollover from 23:59:58.
    step(58 * N);
    chk("roll_h0", int'(hour_counter), 23);
    chk("roll_m0", int'(min_counter), 59);
    chk("roll_s0", int'(sec_counter), 58);
    step(3);
    chk("clk_high_4", int'(clk_1Hz), 1);
    step(1);
    chk("clk_fall", int'(clk_1Hz), 0);
    step(3);
    chk("clk_low_4", int'(clk_1Hz), 0);
    step(1);
    chk("roll_s1", int'(sec_counter), 59);
    step(7);
    chk("roll_hold", int'(sec_counter), 59);
    step(1);
    chk("roll_h", int'(hour_counter), 0);
    chk("roll_m", int'(min_counter), 0);
    chk("roll_s", int'(sec_counter), 0);

    // 12-hour display.
    fmt_12h = 1'b1; step(1);
    chk("h0_12h", int'(hour_counter), 12); chk("h0_pm", int'(pm), 0);
    fmt_12h = 1'b0; step(1);
    chk("h0_24h", int'(hour_counter), 0);
    mode = 2'b01;
    press(0, 12);
    fmt_12h = 1'b1; step(1);
    chk("h12_12h", int'(hour_counter), 12); chk("h12_pm", int'(pm), 1);
    fmt_12h = 1'b0; step(1);
    chk("h12_24h", int'(hour_counter), 12); chk("h12_pm24", int'(pm), 0);
    press(0, 1);
    fmt_12h = 1'b1; step(1);
    chk("h13_12h", int'(hour_counter), 1); chk("h13_pm", int'(pm), 1);
    fmt_12h = 1'b0; step(1);
    chk("h13_24h", int'(hour_counter), 13); chk("h13_pm24", int'(pm), 0);

    // Alarm 00:01 reached from 00:00:00 with natural expiry.
    press(0, 11);
    press(1, 2);
    press(0, 1);
    press(1, 1);
    set_alarm_min_plus_one();
    alarm_en = 1'b1;
    step(57 * N);
    chk("pre_alarm_s", int'(sec_counter), 58);
    chk("pre_alarm_ring", int'(alarm_ring), 0);
    step(2 * N);
    chk("alarm_rise", int'(alarm_ring), 1);
    chk("alarm_rise_m", int'(min_counter), 1);
    step(N);
    chk("alarm_t1", int'(alarm_ring), 1);
    step(N);
    chk("alarm_t2", int'(alarm_ring), 1);
    step(N);
    chk("alarm_expire", int'(alarm_ring), 0);

    // Alarm 00:02 cancelled by a press.
    set_alarm_min_plus_one();
    wait_ring("ring2_wait");
    chk("ring2_m", int'(min_counter), 2);
    chk("ring2_s", int'(sec_counter), 0);
    step(3);
    pushKey = 2'b10;
    step(1);
    chk("press_cancel", int'(alarm_ring), 0);
    pushKey = 2'b11;
    step(1);

    // Both keys in one cycle during set alarm.
    mode = 2'b10;
    pushKey = 2'b00;
    step(1);
    chk("dual_ah", int'(hour_counter), 1);
    chk("dual_field", int'(field_sel), 1);
    pushKey = 2'b11;
    step(2 * N);
    mode = 2'b00;

    // Reset during set time.
    mode = 2'b01;
    press(0, 1);
    reset = 1'b1; step(1);
    reset = 1'b0; mode = 2'b00;
    chk("rst_set_h", int'(hour_counter), 0);
    chk("rst_set_m", int'(min_counter), 0);
    chk("rst_set_field", int'(field_sel), 0);
    step(7);
    chk("rst_set_clk_low", int'(clk_1Hz), 0);
    step(1);
    chk("rst_set_clk_rise", int'(clk_1Hz), 1);

    // Reset during ring.
    set_alarm_min_plus_one();
    wait_ring("ring3_wait");
    step(2);
    reset = 1'b1; step(1);
    reset = 1'b0;
    chk("rst_ring", int'(alarm_ring), 0);
    chk("rst_ring_m", int'(min_counter), 0);
    chk("rst_ring_clk", int'(clk_1Hz), 0);
    step(7);
    chk("rst_ring_clk_low", int'(clk_1Hz), 0);
    step(1);
    chk("rst_ring_clk_rise", int'(clk_1Hz), 1);

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
